nco_poly: RTL and testbench
===========================

// Module: nco_poly
// PURPOSE
//  Multi-voice numerically controlled oscillator with per-voice frequency, waveform and enable.
//  One waveform shaper (sine LUT) is time-shared across voices over a short sweep.
//  Each sweep is triggered by next_sample; the voices are mixed into one offset-binary DAC code.
//  Sits between the audio control registers and the DAC/PWM stage; drop-in superset of the single-voice NCO.
// PARAMETERS
//  N_VOICES  4   number of voices; power of 2, >=1 (mix divides by shift)
//  PA_W      24  phase accumulator width; >=16 (LUT uses top 8 bits, ramps top 14)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  synchronous, active-high reset
//  cfg_we       in   1                  write strobe for voice config
//  cfg_idx      in   max(1,log2 N)      voice index for write
//  cfg_fcw      in   PA_W               frequency control word
//  cfg_mode     in   2                  waveform: 0 sine, 1 square, 2 saw, 3 triangle
//  cfg_en       in   1                  voice enable
//  next_sample  in   1                  1-cycle pulse: produce next mixed sample
//  code         out  14                 mixed output, offset binary (midscale 8192)
//  code_valid   out  1                  1-cycle pulse when code updates
//  busy         out  1                  sweep in progress
//  overrun      out  1                  sticky: next_sample arrived while busy
// BEHAVIOUR
//  Reset: every pa, fcw, en = 0; every mode = sine; code = 8192; code_valid = busy = overrun = 0.
//  FSM states:
//   IDLE -(next_sample)-> SWEEP.
//   SWEEP: voice i = 0..N-1, one per cycle -> DONE.
//   DONE: 1 cycle -> IDLE.
//  Per voice in SWEEP, using pa[i] before update:
//   sine:  sine_lut[pa[PA_W-1 -: 8]].
//   square: msb ? 0 : 16383.
//   saw:   pa[PA_W-1 -: 14].
//   tri:   {msb ? ~t : t, 1'b0}, with t = pa[PA_W-2 -: 13].
//   Enabled voice: acc += sample - 8192 (signed); pa[i] <= pa[i] + fcw[i] mod 2^PA_W (wraps silently).
//   Disabled voice: contributes 0; pa[i] holds.
//  acc width is 15 + log2 N bits, signed; acc is cleared on entry to SWEEP.
//  DONE: code <= 8192 + (acc >>> log2 N); code_valid = 1 for this cycle only.
//   Range provably 0..16383; no saturation needed.
//  Latency: next_sample at cycle t -> code_valid at cycle t+N+1. busy = 1 in SWEEP and DONE.
//  next_sample while busy: ignored (no extra pa advance); overrun <= 1, cleared only by rst.
//  cfg_we: writes fcw/mode/en of cfg_idx at the clock edge, in any state.
//   If SWEEP reads the same voice in that cycle, it uses the old values.
//   pa is never written by cfg.
//  rst mid-sweep: sweep aborted, no code_valid, all state to reset values.
//  code holds its last value between sweeps.
// STRUCTURE
//  Package nco_pkg: CODE_W = 14, MIDSCALE = 14'd8192, LUT_AW = 8, WAVE_SINE/SQUARE/SAW/TRI codes,
//   FSM state encoding (IDLE/SWEEP/DONE).
//  Sub-module nco_wave_gen: combinational; (pa top bits, mode) -> 14-bit sample; wraps the existing sine_lut.
//  Top holds the voice register arrays, pa array, voice counter, FSM, accumulator and output register.
// TESTING
//  1. Reset, then idle 10 cycles -> code = 8192; code_valid, busy, overrun = 0.
//  2. N = 4; voice0 sine, fcw = 24'h010000, others disabled; 3 next_sample pulses ->
//     codes 8192 + ((lut[0..2] - 8192) >>> 2); code_valid exactly 5 cycles after each pulse.
//  3. Voice0 square, fcw = 24'h800000, others off -> codes alternate 10239, 6144.
//     Then all 4 voices square with the same fcw, enabled from reset -> codes alternate 16383, 0.
//  4. Voice0 saw, fcw = 24'hFFFFFF -> pa wraps to 24'hFFFFFF;
//     second sample = 8192 + ((16383 - 8192) >>> 2) = 10239.
//  5. next_sample again 2 cycles after first -> overrun = 1, one code_valid only, pa advanced once.
//  6. rst during SWEEP cycle 2 -> no code_valid; code = 8192; pa = 0.
//     Also: cfg_we to voice 1 in the cycle voice 1 is swept -> old fcw used this sample, new fcw next sample.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared constants, waveform codes, voice control payload and FSM encoding for the polyphonic NCO.
package nco_pkg;

  localparam int unsigned CODE_W   = 14;
  localparam int unsigned LUT_AW   = 8;
  localparam logic [CODE_W-1:0] MIDSCALE = 14'd8192;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_SAW    = 2'd2;
  localparam logic [1:0] WAVE_TRI    = 2'd3;

  // Per-voice control fields written alongside the frequency word
  typedef struct packed {
    logic [1:0] mode;
    logic       en;
  } voice_ctl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/nco_wave_gen.sv
// Combinational waveform shaper shared by all voices.
// Ports: ph (top 14 phase bits), mode (waveform select), sample (14-bit offset binary).
module nco_wave_gen
  import nco_pkg::*;
(
  input  logic [13:0]       ph,
  input  logic [1:0]        mode,
  output logic [CODE_W-1:0] sample
);

  logic [13:0] sine_val;
  logic [12:0] tri_t;

  sine_lut u_sine_lut (
    .addr (ph[13:14-LUT_AW]),
    .data (sine_val)
  );

  always_comb begin
    tri_t  = ph[12:0];
    sample = sine_val;
    case (mode)
      WAVE_SINE:   sample = sine_val;
      WAVE_SQUARE: sample = ph[13] ? 14'd0 : 14'd16383;
      WAVE_SAW:    sample = ph;
      WAVE_TRI:    sample = {(ph[13] ? ~tri_t : tri_t), 1'b0};
      default:     sample = sine_val;
    endcase
  end

endmodule

// File: rtl/sine_lut.sv
// Sine table, 256 entries x 14 bits, offset binary around 8192.
// Each half period is a parabola p*(128-p) scaled to a peak of 8191.
// Ports: addr (phase index), data (sample).
module sine_lut (
  input  logic [7:0]  addr,
  output logic [13:0] data
);

  logic [6:0]  p;
  logic [7:0]  q;
  logic [14:0] prod;
  logic [25:0] scaled;
  logic [12:0] mag;

  always_comb begin
    p      = addr[6:0];
    q      = 8'd128 - {1'b0, p};
    prod   = 15'(p) * 15'(q);
    scaled = 26'(prod) * 26'd8191;
    mag    = 13'(scaled >> 12);
    data   = addr[7] ? (14'd8192 - 14'(mag)) : (14'd8192 + 14'(mag));
  end

endmodule

// File: rtl/nco_poly.sv
// Multi-voice NCO: one shaper time-shared over a sweep of N_VOICES cycles per sample,
// voices mixed into one offset-binary code.
// Ports: clk, rst (sync, active-high); cfg_we/cfg_idx/cfg_fcw/cfg_mode/cfg_en voice config;
//        next_sample trigger; code/code_valid mixed output; busy sweep flag; overrun sticky flag.
module nco_poly
  import nco_pkg::*;
#(
  parameter int unsigned N_VOICES = 4,
  parameter int unsigned PA_W     = 24
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_we,
  input  logic [((N_VOICES > 1) ? $clog2(N_VOICES) : 1)-1:0] cfg_idx,
  input  logic [PA_W-1:0]                           cfg_fcw,
  input  logic [1:0]                                cfg_mode,
  input  logic                                      cfg_en,
  input  logic                                      next_sample,
  output logic [13:0]                               code,
  output logic                                      code_valid,
  output logic                                      busy,
  output logic                                      overrun
);

  localparam int unsigned IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int unsigned SH    = $clog2(N_VOICES);
  localparam int unsigned ACC_W = 15 + SH;

  logic [PA_W-1:0]  pa_q  [N_VOICES];
  logic [PA_W-1:0]  fcw_q [N_VOICES];
  voice_ctl_t       ctl_q [N_VOICES];

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          vidx_q, vidx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   contrib, acc_sum;
  logic [CODE_W-1:0]         code_q, code_d;
  logic                      code_valid_q, code_valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;
  logic                      pa_adv;
  logic [CODE_W-1:0]         sample;

  nco_wave_gen u_wave_gen (
    .ph     (pa_q[vidx_q][PA_W-1 -: 14]),
    .mode   (ctl_q[vidx_q].mode),
    .sample (sample)
  );

  // Next-state, mixing and output decode
  always_comb begin
    state_d      = state_q;
    vidx_d       = vidx_q;
    acc_d        = acc_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    overrun_d    = overrun_q;
    pa_adv       = 1'b0;
    contrib      = ctl_q[vidx_q].en ?
                   ($signed(ACC_W'(sample)) - $signed(ACC_W'(MIDSCALE))) : '0;
    acc_sum      = acc_q + contrib;

    case (state_q)
      ST_IDLE: begin
        if (next_sample) begin
          state_d = ST_SWEEP;
          vidx_d  = '0;
          acc_d   = '0;
        end
      end
      ST_SWEEP: begin
        acc_d  = acc_sum;
        pa_adv = ctl_q[vidx_q].en;
        if (vidx_q == IDX_W'(N_VOICES - 1)) begin
          // Registered here so the code is presented during the DONE cycle
          state_d      = ST_DONE;
          code_d       = MIDSCALE + CODE_W'(acc_sum >>> SH);
          code_valid_d = 1'b1;
        end else begin
          vidx_d = vidx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (next_sample && (state_q != ST_IDLE)) overrun_d = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  // State, voice and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vidx_q       <= '0;
      acc_q        <= '0;
      code_q       <= MIDSCALE;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < int'(N_VOICES); i++) begin
        pa_q[i]  <= '0;
        fcw_q[i] <= '0;
        ctl_q[i] <= '{mode: WAVE_SINE, en: 1'b0};
      end
    end else begin
      state_q      <= state_d;
      vidx_q       <= vidx_d;
      acc_q        <= acc_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      if (cfg_we) begin
        fcw_q[cfg_idx] <= cfg_fcw;
        ctl_q[cfg_idx] <= '{mode: cfg_mode, en: cfg_en};
      end
      // Sweep reads old cfg values because both updates are non-blocking
      if (pa_adv) pa_q[vidx_q] <= pa_q[vidx_q] + fcw_q[vidx_q];
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_nco_poly.sv
// Self-checking bench for nco_poly with a behavioural voice/mix model.
module tb_nco_poly;

  localparam int N    = 4;
  localparam int PA_W = 24;
  localparam longint PA_MOD = 64'd1 << PA_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [23:0] cfg_fcw = '0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_en = 1'b0;
  logic        next_sample = 1'b0;
  logic [13:0] code;
  logic        code_valid;
  logic        busy;
  logic        overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  longint m_pa [N];
  longint m_fcw[N];
  int     m_mode[N];
  bit     m_en [N];

  int     p_idx;
  longint p_fcw;
  int     p_mode;
  bit     p_en;

  nco_poly #(.N_VOICES(N), .PA_W(PA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_fcw     (cfg_fcw),
    .cfg_mode    (cfg_mode),
    .cfg_en      (cfg_en),
    .next_sample (next_sample),
    .code        (code),
    .code_valid  (code_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wave(input longint pa, input int mode);
    int ph, idx, p, mag;
    ph = int'(pa >> (PA_W - 14));
    case (mode)
      0: begin
        idx = ph / 64;
        p   = idx % 128;
        mag = (p * (128 - p) * 8191) / 4096;
        return (idx < 128) ? 8192 + mag : 8192 - mag;
      end
      1:       return (ph < 8192) ? 16383 : 0;
      2:       return ph;
      default: return (ph < 8192) ? 2 * ph : 2 * (16383 - ph);
    endcase
  endfunction

  function automatic int floor_div(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  // Expected mixed code for the next sample; advances the model phases
  function automatic int model_sample();
    int sum = 0;
    for (int i = 0; i < N; i++) begin
      if (m_en[i]) begin
        sum += wave(m_pa[i], m_mode[i]) - 8192;
        m_pa[i] = (m_pa[i] + m_fcw[i]) % PA_MOD;
      end
    end
    return 8192 + floor_div(sum, N);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pa[i] = 0; m_fcw[i] = 0; m_mode[i] = 0; m_en[i] = 0;
    end
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int idx, input longint fcw, input int mode, input bit en);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_fcw = 24'(fcw); cfg_mode = 2'(mode); cfg_en = en;
    @(posedge clk); #1 cfg_we = 1'b0;
    m_fcw[idx] = fcw; m_mode[idx] = mode; m_en[idx] = en;
  endtask

  // One next_sample pulse observed over a fixed 12-edge window.
  // Edge k counts from the edge that samples the pulse being driven (k=1).
  task automatic run_sample(input string tag, input int pulse2_at, input int cfg_at,
                            input int rst_at, output int got_code);
    int exp_code = 0;
    int first_k  = -1;
    int n_valid  = 0;
    logic busy_k1 = 1'b0;
    got_code = -1;
    if (rst_at < 0) exp_code = model_sample();
    @(posedge clk); #1 next_sample = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      next_sample = (k == pulse2_at);
      rst         = (k == rst_at);
      cfg_we      = (k == cfg_at);
      if (k == cfg_at) begin
        cfg_idx = 2'(p_idx); cfg_fcw = 24'(p_fcw); cfg_mode = 2'(p_mode); cfg_en = p_en;
      end
      if (k == 1) busy_k1 = busy;
      if (code_valid === 1'b1) begin
        n_valid++;
        if (first_k < 0) begin
          first_k  = k;
          got_code = int'(code);
        end
      end
    end
    if (cfg_at > 0) begin
      m_fcw[p_idx] = p_fcw; m_mode[p_idx] = p_mode; m_en[p_idx] = p_en;
    end
    if (rst_at < 0) begin
      check({tag, "_latency"}, 64'(first_k), 64'd5);
      check({tag, "_code"}, 64'(got_code), 64'(exp_code));
      check({tag, "_nvalid"}, 64'(n_valid), 64'd1);
      check({tag, "_busy"}, 64'(busy_k1), 64'd1);
      check({tag, "_idle"}, 64'(busy), 64'd0);
    end else begin
      check({tag, "_nvalid"}, 64'(n_valid), 64'd0);
      check({tag, "_code"}, 64'(code), 64'd8192);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_overrun"}, 64'(overrun), 64'd0);
      model_reset();
    end
  endtask

  initial begin
    int c;
    model_reset();

    // Reset and idle
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check("rst_code", 64'(code), 64'd8192);
    check("rst_valid", 64'(code_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // Single sine voice
    cfg_write(0, 64'h010000, 0, 1'b1);
    for (int s = 0; s < 3; s++) run_sample($sformatf("sine%0d", s), -1, -1, -1, c);

    // Square: one voice, then all four
    do_reset();
    cfg_write(0, 64'h800000, 1, 1'b1);
    run_sample("sq1a", -1, -1, -1, c); check("sq1a_lit", 64'(c), 64'd10239);
    run_sample("sq1b", -1, -1, -1, c); check("sq1b_lit", 64'(c), 64'd6144);
    do_reset();
    for (int v = 0; v < N; v++) cfg_write(v, 64'h800000, 1, 1'b1);
    run_sample("sq4a", -1, -1, -1, c); check("sq4a_lit", 64'(c), 64'd16383);
    run_sample("sq4b", -1, -1, -1, c); check("sq4b_lit", 64'(c), 64'd0);

    // Saw with maximal fcw wraps
    do_reset();
    cfg_write(0, 64'hFFFFFF, 2, 1'b1);
    run_sample("sawa", -1, -1, -1, c); check("sawa_lit", 64'(c), 64'd6144);
    run_sample("sawb", -1, -1, -1, c); check("sawb_lit", 64'(c), 64'd10239);

    // next_sample while busy
    do_reset();
    cfg_write(0, 64'h100000, 2, 1'b1);
    run_sample("ovr", 2, -1, -1, c);
    check("ovr_flag", 64'(overrun), 64'd1);
    run_sample("ovr_next", -1, -1, -1, c);
    check("ovr_sticky", 64'(overrun), 64'd1);
    do_reset();
    #1 check("ovr_cleared", 64'(overrun), 64'd0);

    // Reset mid-sweep
    cfg_write(0, 64'h123456, 3, 1'b1);
    cfg_write(2, 64'h0ABCDE, 0, 1'b1);
    run_sample("pre_rst", -1, -1, -1, c);
    run_sample("mid_rst", -1, -1, 2, c);
    cfg_write(0, 64'h200000, 2, 1'b1);
    run_sample("post_rst", -1, -1, -1, c);
    check("post_rst_lit", 64'(c), 64'd6144);

    // cfg write to voice 1 in the cycle it is swept
    do_reset();
    cfg_write(0, 64'h040000, 2, 1'b1);
    cfg_write(1, 64'h100000, 2, 1'b1);
    p_idx = 1; p_fcw = 64'h300000; p_mode = 3; p_en = 1'b1;
    run_sample("cfgsw0", -1, 2, -1, c);
    run_sample("cfgsw1", -1, -1, -1, c);
    run_sample("cfgsw2", -1, -1, -1, c);

    // Randomized voice configurations
    do_reset();
    for (int r = 0; r < 20; r++) begin
      int nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(0, N - 1)), longint'($urandom) % PA_MOD,
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int s = 0; s < int'($urandom_range(1, 3)); s++)
        run_sample($sformatf("rnd%0d_%0d", r, s), -1, -1, -1, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
